// File: rtl/ram_word_ctrl_pkg.sv
// Shared types and default geometry for the word-level RAM access controller.
package ram_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Default RAM geometry: 16 x 2-bit RAM, 4 beats per word
    localparam int RAM_DW_DEF = 2;
    localparam int RAM_AW_DEF = 4;
    localparam int BEATS_DEF  = 4;

    // Derived word geometry
    localparam int WORD_W  = RAM_DW_DEF * BEATS_DEF;
    localparam int WADDR_W = RAM_AW_DEF - $clog2(BEATS_DEF);

endpackage

// File: rtl/ram_word_ctrl.sv
// Word-level access controller: turns one 8-bit word request into a burst of
// 2-bit RAM accesses (4 write beats, or 5 read cycles to cover the RAM's
// registered output) and returns exactly one response per accepted request.
module ram_word_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int RAM_DW = RAM_DW_DEF,
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int BEATS  = BEATS_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_write,
    input  logic [RAM_AW-$clog2(BEATS)-1:0]       req_addr,
    input  logic [RAM_DW*BEATS-1:0]               req_wdata,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [RAM_DW*BEATS-1:0]               rsp_rdata,
    output logic                                  ram_we,
    output logic                                  ram_oe,
    output logic [RAM_AW-1:0]                     ram_addr,
    output logic [RAM_DW-1:0]                     ram_wdata,
    input  logic [RAM_DW-1:0]                     ram_rdata
);

    localparam int BW = $clog2(BEATS);     // beat index bits
    localparam int WW = RAM_DW * BEATS;    // word width
    localparam int AW = RAM_AW - BW;       // word address width
    localparam int KW = BW + 1;            // counter also reaches BEATS for the read tail

    localparam logic [KW-1:0] LAST_WR = KW'(BEATS - 1);
    localparam logic [KW-1:0] LAST_RD = KW'(BEATS);

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [WW-1:0]       wdata_q, wdata_d;
    logic [WW-1:0]       rdata_q, rdata_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_oe_q, ram_oe_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [RAM_DW-1:0]   ram_wdata_q, ram_wdata_d;
    logic [WW-1:0]       rsp_rdata_q, rsp_rdata_d;

    logic [BW-1:0]       rd_beat;   // beat whose data is on ram_rdata this cycle
    logic [BW-1:0]       beat_d;    // beat driven to the RAM next cycle

    // Returned data lags the address by one cycle, so cycle j carries beat j-1.
    assign rd_beat = k_q[BW-1:0] - BW'(1);

    // Next-state, burst sequencing and read-word assembly
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    k_d     = '0;
                    state_d = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (k_q == LAST_WR) state_d = RESP;
                else                k_d     = k_q + KW'(1);
            end
            READ: begin
                if (k_q != '0) rdata_d[rd_beat*RAM_DW +: RAM_DW] = ram_rdata;
                if (k_q == LAST_RD) state_d = RESP;
                else                k_d     = k_q + KW'(1);
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM-side and response outputs, registered from the next state so they
    // line up with the cycle the state machine enters
    always_comb begin
        beat_d      = (k_d > LAST_WR) ? BW'(BEATS - 1) : k_d[BW-1:0];
        ram_we_d    = (state_d == WRITE);
        ram_oe_d    = (state_d == READ);
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        rsp_rdata_d = '0;
        if (ram_we_d || ram_oe_d) ram_addr_d  = {addr_d, beat_d};
        if (ram_we_d)             ram_wdata_d = wdata_d[beat_d*RAM_DW +: RAM_DW];
        if (state_d == RESP)      rsp_rdata_d = rdata_d;
    end

    // State and output registers; reset aborts any burst without a response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_word_ctrl.sv
// Bench for ram_word_ctrl: behavioural 16x2 RAM with registered output,
// word-level reference memory, table vectors, reset corner cases, random traffic.
module tb_ram_word_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       ram_we, ram_oe;
    logic [3:0] ram_addr;
    logic [1:0] ram_wdata, ram_rdata;

    int tests = 0;
    int fails = 0;
    int both_hi = 0;

    logic [1:0] mem [16];
    logic [7:0] model [4];   // expected word contents

    always #5 clk = ~clk;

    ram_word_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // 16 x 2 RAM: synchronous write, registered read output
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_oe) ram_rdata <= mem[ram_addr];
    end

    // we and oe must never be high together
    always @(negedge clk) if (ram_we && ram_oe) both_hi++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request at a negedge with the controller idle, follow the burst
    // cycle by cycle, hold rsp_ready low for 'hold' cycles (optionally with a
    // competing request), then handshake. Returns the response word.
    task automatic run_txn(input logic w, input logic [1:0] a, input logic [7:0] d,
                           input int hold, input logic pend, output logic [7:0] rd);
        int we_n = 0, oe_n = 0, lat = 0;
        int ea;
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 2'($urandom); req_wdata = 8'($urandom);
        req_write = 1'($urandom);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = n; break; end
            if (ram_we) begin
                chk("wr_addr", 32'(ram_addr), 32'({a, 2'(we_n)}));
                chk("wr_data", 32'(ram_wdata), 32'((d >> (2 * we_n)) & 8'h3));
                we_n++;
            end
            if (ram_oe) begin
                ea = (oe_n > 3) ? 3 : oe_n;
                chk("rd_addr", 32'(ram_addr), 32'({a, 2'(ea)}));
                oe_n++;
            end
        end
        chk("rsp_latency", 32'(lat), w ? 32'd5 : 32'd6);
        chk("we_cycles", 32'(we_n), w ? 32'd4 : 32'd0);
        chk("oe_cycles", 32'(oe_n), w ? 32'd0 : 32'd5);
        rd = rsp_rdata;
        if (pend) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = ~a; req_wdata = 8'hEE;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_rdata), 32'(rd));
            chk("hold_not_ready", 32'(req_ready), 32'd0);
            chk("hold_no_ram", 32'({ram_we, ram_oe}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_no_rsp", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t       vt [10];
    logic [7:0] rd;

    initial begin
        vt[0] = '{1'b1, 2'd2, 8'hB4, 8'h00};
        vt[1] = '{1'b0, 2'd2, 8'h00, 8'hB4};
        vt[2] = '{1'b1, 2'd0, 8'h00, 8'h00};
        vt[3] = '{1'b1, 2'd1, 8'hFF, 8'h00};
        vt[4] = '{1'b1, 2'd2, 8'h5A, 8'h00};
        vt[5] = '{1'b1, 2'd3, 8'hC3, 8'h00};
        vt[6] = '{1'b0, 2'd0, 8'h00, 8'h00};
        vt[7] = '{1'b0, 2'd1, 8'h00, 8'hFF};
        vt[8] = '{1'b0, 2'd2, 8'h00, 8'h5A};
        vt[9] = '{1'b0, 2'd3, 8'h00, 8'hC3};

        for (int i = 0; i < 16; i++) mem[i] = 2'd0;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        ram_rdata = 2'd0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0;
        req_wdata = 8'h00; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ram", 32'({ram_we, ram_oe, ram_addr, ram_wdata}), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b0;

        // table-driven vectors
        foreach (vt[i]) begin
            run_txn(vt[i].w, vt[i].a, vt[i].d, 0, 1'b0, rd);
            chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp));
            if (vt[i].w) model[vt[i].a] = vt[i].d;
        end

        // response back-pressure with a competing request
        run_txn(1'b0, 2'd3, 8'h00, 3, 1'b1, rd);
        chk("bp_rdata", 32'(rd), 32'(model[3]));
        run_txn(1'b0, 2'd0, 8'h00, 0, 1'b0, rd);
        chk("bp_no_stray_write", 32'(rd), 32'(model[0]));

        // reset during read cycle j=2
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);           // cycles j=0,1,2
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rdrst_oe", 32'(ram_oe), 32'd0);
        chk("rdrst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) chk("rdrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("rdrst_idle", 32'({rsp_valid, ram_oe, ram_we}), 32'd0);
        run_txn(1'b0, 2'd2, 8'h00, 0, 1'b0, rd);
        chk("rdrst_reread", 32'(rd), 32'(model[2]));

        // reset launched on the edge that would start write beat 2
        run_txn(1'b1, 2'd1, 8'h00, 0, 1'b0, rd);
        model[1] = 8'h00;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'hFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);           // beats 0 and 1 on the bus
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("wrrst_we", 32'(ram_we), 32'd0);
        chk("wrrst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) chk("wrrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        model[1] = 8'h0F;
        chk("wrrst_k0", 32'(mem[4]), 32'd3);
        chk("wrrst_k1", 32'(mem[5]), 32'd3);
        chk("wrrst_k2", 32'(mem[6]), 32'd0);
        chk("wrrst_k3", 32'(mem[7]), 32'd0);
        run_txn(1'b0, 2'd1, 8'h00, 0, 1'b0, rd);
        chk("wrrst_word", 32'(rd), 32'h0F);

        // random traffic against the word model
        for (int i = 0; i < 40; i++) begin
            logic       w;
            logic [1:0] a;
            logic [7:0] d;
            w = 1'($urandom);
            a = 2'($urandom);
            d = 8'($urandom);
            run_txn(w, a, d, int'($urandom_range(0, 2)), 1'b0, rd);
            if (w) begin
                chk("rnd_wr_rdata", 32'(rd), 32'd0);
                model[a] = d;
            end else begin
                chk("rnd_rd_rdata", 32'(rd), 32'(model[a]));
            end
        end

        chk("we_oe_exclusive", 32'(both_hi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // hard stop if something wedges the sequence
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
